// File: rtl/attn_v_spikes_unpacking_pkg.sv
// Shared shape constants for the attn@v spike packer/unpacker pair.
// TIME_STEPS / PATCH_EMBED_WIDTH follow the hyper-parameter macros when defined.
`ifndef TIME_STEPS
`define TIME_STEPS 4
`endif
`ifndef PATCH_EMBED_WIDTH
`define PATCH_EMBED_WIDTH 32
`endif
package attn_v_spikes_unpacking_pkg;
  localparam int TIME_STEPS        = `TIME_STEPS;
  localparam int PATCH_EMBED_WIDTH = `PATCH_EMBED_WIDTH;

  localparam int BEATS  = PATCH_EMBED_WIDTH / TIME_STEPS;
  localparam int BEAT_W = 2 * TIME_STEPS;
  localparam int WORD_W = 2 * PATCH_EMBED_WIDTH;
  localparam int IDX_W  = $clog2(BEATS);

  typedef enum logic [1:0] {ST_EMPTY, ST_ACTIVE, ST_FULL} unpack_state_e;

  // Occupancy flags map onto the three legal states; pending without active never occurs.
  function automatic unpack_state_e unpack_state(input logic active_full, input logic pend_full);
    if (!active_full)    return ST_EMPTY;
    else if (!pend_full) return ST_ACTIVE;
    else                 return ST_FULL;
  endfunction
endpackage

// File: rtl/attn_v_spikes_unpacking.sv
// Splits one packed spike word into BEATS narrow beats, beat 0 first, with a
// one-word pending buffer so back-to-back words stream without bubbles.
module attn_v_spikes_unpacking
  import attn_v_spikes_unpacking_pkg::*;
(
  input  logic              s_clk,
  input  logic              s_rst,
  input  logic [WORD_W-1:0] i_spikes_word,
  input  logic              i_word_valid,
  output logic              o_word_ready,
  output logic [BEAT_W-1:0] o_spikes_out_ext,
  output logic              o_spikes_valid,
  input  logic              i_spikes_ready,
  output logic [IDX_W-1:0]  o_beat_idx,
  output logic              o_last
);
  if (BEATS < 2 || (BEATS & (BEATS - 1)) != 0) begin : g_bad_beats
    $error("attn_v_spikes_unpacking: BEATS must be a power of two >= 2");
  end

  logic [WORD_W-1:0] active_q, active_d, pend_q, pend_d;
  logic              active_full_q, active_full_d, pend_full_q, pend_full_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              at_last, out_fire, in_fire, last_fire;
  unpack_state_e     state;

  assign state     = unpack_state(active_full_q, pend_full_q);
  assign at_last   = cnt_q == IDX_W'(BEATS - 1);
  assign out_fire  = active_full_q && i_spikes_ready;
  assign in_fire   = i_word_valid && !pend_full_q;
  assign last_fire = out_fire && at_last;

  always_comb begin
    active_d      = active_q;
    pend_d        = pend_q;
    active_full_d = active_full_q;
    pend_full_d   = pend_full_q;
    cnt_d         = cnt_q;
    case (state)
      ST_EMPTY: begin
        if (in_fire) begin
          active_d      = i_spikes_word;
          active_full_d = 1'b1;
          cnt_d         = '0;
        end
      end
      ST_ACTIVE: begin
        if (out_fire) cnt_d = cnt_q + IDX_W'(1);
        if (last_fire) cnt_d = '0;
        // A word arriving on the last beat goes straight to active: no bubble.
        if (last_fire && in_fire) begin
          active_d = i_spikes_word;
        end else if (last_fire) begin
          active_full_d = 1'b0;
        end else if (in_fire) begin
          pend_d      = i_spikes_word;
          pend_full_d = 1'b1;
        end
      end
      ST_FULL: begin
        if (out_fire) cnt_d = cnt_q + IDX_W'(1);
        if (last_fire) begin
          cnt_d       = '0;
          active_d    = pend_q;
          pend_full_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      active_q      <= '0;
      pend_q        <= '0;
      active_full_q <= 1'b0;
      pend_full_q   <= 1'b0;
      cnt_q         <= '0;
    end else begin
      active_q      <= active_d;
      pend_q        <= pend_d;
      active_full_q <= active_full_d;
      pend_full_q   <= pend_full_d;
      cnt_q         <= cnt_d;
    end
  end

  assign o_word_ready     = !pend_full_q;
  assign o_spikes_valid   = active_full_q;
  assign o_beat_idx       = cnt_q;
  assign o_last           = active_full_q && at_last;
  assign o_spikes_out_ext = active_q[cnt_q*BEAT_W +: BEAT_W];
endmodule

// File: tb/tb_attn_v_spikes_unpacking.sv
// Random + directed bench for attn_v_spikes_unpacking against a beat-queue model
// and a re-packing round-trip check.
module tb_attn_v_spikes_unpacking;
  import attn_v_spikes_unpacking_pkg::*;

  logic              s_clk = 1'b0;
  logic              s_rst = 1'b1;
  logic [WORD_W-1:0] i_spikes_word = '0;
  logic              i_word_valid = 1'b0;
  logic              o_word_ready;
  logic [BEAT_W-1:0] o_spikes_out_ext;
  logic              o_spikes_valid;
  logic              i_spikes_ready = 1'b1;
  logic [IDX_W-1:0]  o_beat_idx;
  logic              o_last;

  attn_v_spikes_unpacking dut (
    .s_clk(s_clk), .s_rst(s_rst),
    .i_spikes_word(i_spikes_word), .i_word_valid(i_word_valid), .o_word_ready(o_word_ready),
    .o_spikes_out_ext(o_spikes_out_ext), .o_spikes_valid(o_spikes_valid),
    .i_spikes_ready(i_spikes_ready), .o_beat_idx(o_beat_idx), .o_last(o_last)
  );

  always #5 s_clk = ~s_clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the exact sequence of beats still owed to the consumer, plus accepted words.
  typedef struct {
    logic [BEAT_W-1:0] d;
    int                idx;
    bit                last;
  } beat_t;
  beat_t             q[$];
  logic [WORD_W-1:0] words[$];
  logic [WORD_W-1:0] rebuilt = '0;

  always @(negedge s_clk) begin
    if (s_rst) begin
      check("rst_valid", 64'(o_spikes_valid), 64'(0));
      check("rst_data",  64'(o_spikes_out_ext), 64'(0));
      check("rst_idx",   64'(o_beat_idx), 64'(0));
      check("rst_last",  64'(o_last), 64'(0));
      check("rst_ready", 64'(o_word_ready), 64'(1));
      q.delete();
      words.delete();
    end else begin
      // Two words in flight means more than one word's worth of beats still owed.
      check("ready", 64'(o_word_ready), 64'(q.size() <= BEATS));
      check("valid", 64'(o_spikes_valid), 64'(q.size() != 0));
      if (q.size() != 0) begin
        check("data", 64'(o_spikes_out_ext), 64'(q[0].d));
        check("idx",  64'(o_beat_idx), 64'(q[0].idx));
        check("last", 64'(o_last), 64'(q[0].last));
      end
      if (o_spikes_valid && i_spikes_ready) begin
        if (q.size() != 0) void'(q.pop_front());
        rebuilt[o_beat_idx*BEAT_W +: BEAT_W] = o_spikes_out_ext;
        if (o_last) begin
          if (words.size() == 0) check("roundtrip_orphan", 64'(1), 64'(0));
          else check("roundtrip", 64'(rebuilt), 64'(words.pop_front()));
        end
      end
      if (i_word_valid && o_word_ready) begin
        words.push_back(i_spikes_word);
        for (int k = 0; k < BEATS; k++) begin
          beat_t b;
          b.d    = BEAT_W'(i_spikes_word >> (k * BEAT_W));
          b.idx  = k;
          b.last = (k == BEATS - 1);
          q.push_back(b);
        end
      end
    end
  end

  task automatic tick;
    @(posedge s_clk);
    #1;
  endtask

  task automatic drain;
    i_word_valid   = 1'b0;
    i_spikes_ready = 1'b1;
    repeat (20) tick();
  endtask

  logic [WORD_W-1:0] w3;
  int                n;

  initial begin
    tick();
    check("init_ready", 64'(o_word_ready), 64'(1));
    check("init_valid", 64'(o_spikes_valid), 64'(0));
    tick();
    s_rst = 1'b0;
    tick();

    // Single word, free-flowing consumer.
    i_spikes_word = 64'h8877665544332211; i_word_valid = 1'b1; i_spikes_ready = 1'b1;
    tick();
    i_word_valid = 1'b0; i_spikes_word = '0;
    for (int k = 0; k < 8; k++) begin
      check("t1_valid", 64'(o_spikes_valid), 64'(1));
      check("t1_beat",  64'(o_spikes_out_ext), 64'(8'h11 * (k + 1)));
      check("t1_idx",   64'(o_beat_idx), 64'(k));
      check("t1_last",  64'(o_last), 64'(k == 7));
      tick();
    end
    check("t1_done", 64'(o_spikes_valid), 64'(0));
    drain();

    // Back-to-back words stream with no gap.
    i_spikes_word = 64'h0807060504030201; i_word_valid = 1'b1;
    tick();
    check("t2_beat0", 64'(o_spikes_out_ext), 64'h01);
    i_spikes_word = 64'hF8F7F6F5F4F3F2F1;
    tick();
    i_word_valid = 1'b0;
    for (int k = 1; k < 16; k++) begin
      check("t2_valid", 64'(o_spikes_valid), 64'(1));
      check("t2_beat",  64'(o_spikes_out_ext), (k < 8) ? 64'(k + 1) : 64'(8'hF1 + (k - 8)));
      check("t2_ready", 64'(o_word_ready), 64'(k >= 8));
      tick();
    end
    check("t2_done", 64'(o_spikes_valid), 64'(0));
    drain();

    // Consumer ready pattern 1,0,0 repeating.
    i_spikes_word = {$urandom, $urandom}; i_word_valid = 1'b1;
    tick();
    i_word_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      i_spikes_ready = (c % 3 == 0);
      tick();
    end
    check("t3_done", 64'(o_spikes_valid), 64'(0));
    drain();

    // Fill both buffers while the consumer stalls.
    i_spikes_ready = 1'b0;
    i_spikes_word = {$urandom, $urandom}; i_word_valid = 1'b1;
    tick();
    i_spikes_word = {$urandom, $urandom};
    tick();
    i_spikes_word = {$urandom, $urandom};
    check("t4_blocked", 64'(o_word_ready), 64'(0));
    tick();
    check("t4_blocked2", 64'(o_word_ready), 64'(0));
    i_spikes_ready = 1'b1;
    n = 0;
    while (!o_word_ready && n < 20) begin
      tick();
      n++;
    end
    check("t4_ready_latency", 64'(n), 64'(8));
    tick();
    drain();

    // Async reset with a word pending.
    i_spikes_word = {$urandom, $urandom}; i_word_valid = 1'b1;
    tick();
    i_spikes_word = {$urandom, $urandom};
    tick();
    i_word_valid = 1'b0;
    tick(); tick();
    check("t5_idx3", 64'(o_beat_idx), 64'(3));
    #2 s_rst = 1'b1;
    #1;
    check("t5_valid", 64'(o_spikes_valid), 64'(0));
    check("t5_data",  64'(o_spikes_out_ext), 64'(0));
    check("t5_last",  64'(o_last), 64'(0));
    check("t5_ready", 64'(o_word_ready), 64'(1));
    tick();
    s_rst = 1'b0;
    w3 = {$urandom, $urandom};
    i_spikes_word = w3; i_word_valid = 1'b1;
    tick();
    i_word_valid = 1'b0;
    check("t5_new_beat0", 64'(o_spikes_out_ext), 64'(w3[BEAT_W-1:0]));
    check("t5_new_idx",   64'(o_beat_idx), 64'(0));
    drain();

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      i_word_valid   = ($urandom % 4) != 0;
      i_spikes_word  = {$urandom, $urandom};
      i_spikes_ready = ($urandom % 4) != 0;
      if ($urandom % 700 == 0) begin
        #2 s_rst = 1'b1;
        tick();
        s_rst = 1'b0;
      end else begin
        tick();
      end
    end
    drain();
    check("final_empty", 64'(o_spikes_valid), 64'(0));
    check("final_words", 64'(words.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
